// File: rtl/pipe_pkg.sv
// Shared widths and occupancy encoding for the skid-buffered pipeline register.
// MAIN valid is bit 0, SKID valid is bit 1 of the occupancy code.
package pipe_pkg;
  localparam int DATA_W_D   = 32;
  localparam int NUM_DATA_D = 2;
  localparam int CTRL_W_D   = 2;
  localparam int WN_W_D     = 5;
  localparam int STALL_W    = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_e;
endpackage

// File: rtl/pipe_entry_reg.sv
// Load-enabled holding register for one pipeline entry (ctrl, wn, data).
// ctrl has its own synchronous clear so a flushed entry can never write back.
module pipe_entry_reg #(
  parameter int CTRL_W = 2,
  parameter int WN_W   = 5,
  parameter int D_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [WN_W-1:0]   wn_i,
  input  logic [D_W-1:0]    data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [WN_W-1:0]   wn_o,
  output logic [D_W-1:0]    data_o
);
  logic [CTRL_W-1:0] ctrl_q;
  logic [WN_W-1:0]   wn_q;
  logic [D_W-1:0]    data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      wn_q   <= '0;
      data_q <= '0;
    end else begin
      if (clr_ctrl_i)  ctrl_q <= '0;
      else if (load_i) ctrl_q <= ctrl_i;
      if (load_i) begin
        wn_q   <= wn_i;
        data_q <= data_i;
      end
    end
  end

  assign ctrl_o = ctrl_q;
  assign wn_o   = wn_q;
  assign data_o = data_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register: MAIN drives the outputs, SKID absorbs
// one extra entry so in_ready depends only on registered state.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int NUM_DATA = NUM_DATA_D,
  parameter int CTRL_W   = CTRL_W_D,
  parameter int WN_W     = WN_W_D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_reg,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [WN_W-1:0]            in_wn,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [WN_W-1:0]            out_wn,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [STALL_W-1:0]         stall_cnt
);
  localparam int D_W = NUM_DATA * DATA_W;

  logic main_v_q, main_v_d;
  logic skid_v_q, skid_v_d;
  logic [STALL_W-1:0] stall_q;

  logic main_load, skid_load, main_from_skid;
  logic push, pop;
  occ_e occ;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [WN_W-1:0]   main_wn, skid_wn, main_wn_in;
  logic [D_W-1:0]    main_data, skid_data, main_data_in;

  assign occ       = occ_e'({skid_v_q, main_v_q});
  assign in_ready  = en_reg & ~skid_v_q;
  assign out_valid = en_reg & main_v_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    main_v_d       = main_v_q;
    skid_v_d       = skid_v_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (en_reg) begin
      unique case (occ)
        EMPTY: begin
          main_load = push;
          main_v_d  = push;
        end
        ONE: begin
          if (push && !pop) begin
            skid_load = 1'b1;
            skid_v_d  = 1'b1;
          end else if (pop && !push) begin
            main_v_d = 1'b0;
          end else if (push && pop) begin
            main_load = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_v_d       = 1'b0;
          end
        end
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_wn_in   = main_from_skid ? skid_wn   : in_wn;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      // Counts independently of flush; saturates rather than wraps.
      if (en_reg && main_v_q && !out_ready && stall_q != '1)
        stall_q <= stall_q + 1'b1;
    end
  end

  pipe_entry_reg #(
    .CTRL_W(CTRL_W), .WN_W(WN_W), .D_W(D_W)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .load_i    (main_load),
    .clr_ctrl_i(flush),
    .ctrl_i    (main_ctrl_in),
    .wn_i      (main_wn_in),
    .data_i    (main_data_in),
    .ctrl_o    (main_ctrl),
    .wn_o      (main_wn),
    .data_o    (main_data)
  );

  pipe_entry_reg #(
    .CTRL_W(CTRL_W), .WN_W(WN_W), .D_W(D_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load_i    (skid_load),
    .clr_ctrl_i(flush),
    .ctrl_i    (in_ctrl),
    .wn_i      (in_wn),
    .data_i    (in_data),
    .ctrl_o    (skid_ctrl),
    .wn_o      (skid_wn),
    .data_o    (skid_data)
  );

  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_wn    = main_wn;
  assign out_data  = main_data;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based model of the two-entry stage
// plus literal spot checks of the directed scenarios.
module tb_pipe_skid_reg;
  logic        clk, rst, en_reg, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_ctrl, out_ctrl;
  logic [4:0]  in_wn, out_wn;
  logic [63:0] in_data, out_data;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ctrl;
    logic [4:0]  wn;
    logic [63:0] data;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  last_wn;
  logic [63:0] last_data;
  logic [15:0] stall_m;

  pipe_skid_reg dut (
    .clk      (clk),
    .rst      (rst),
    .en_reg   (en_reg),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_wn    (in_wn),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_wn   (out_wn),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_wn   = '0;
    last_data = '0;
    stall_m   = '0;
  endtask

  task automatic model_step();
    int   n;
    ent_t e;
    bit   p, u;
    n = q.size();
    e.ctrl = in_ctrl;
    e.wn   = in_wn;
    e.data = in_data;
    if (en_reg && n > 0 && !out_ready && stall_m != 16'hFFFF)
      stall_m++;
    if (flush) begin
      q.delete();
    end else if (en_reg) begin
      p = out_ready && n > 0;
      u = in_valid && n < 2;
      if (p) void'(q.pop_front());
      if (u) q.push_back(e);
    end
    if (q.size() > 0) begin
      last_wn   = q[0].wn;
      last_data = q[0].data;
    end
  endtask

  task automatic compare();
    logic       ov;
    logic [1:0] oc;
    ov = en_reg && q.size() > 0;
    oc = ov ? q[0].ctrl : 2'b00;
    chk("in_ready", 64'(in_ready), 64'(en_reg && q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(ov));
    chk("out_ctrl", 64'(out_ctrl), 64'(oc));
    chk("out_wn", 64'(out_wn), 64'(last_wn));
    chk("out_data", out_data, last_data);
    chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(logic v, logic [1:0] c, logic [4:0] w,
                       logic [31:0] d1, logic [31:0] d0);
    in_valid = v;
    in_ctrl  = c;
    in_wn    = w;
    in_data  = {d1, d0};
  endtask

  initial begin
    rst = 1'b0; en_reg = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
    model_reset();
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_wn", 64'(out_wn), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // single entry, 1-cycle latency
    drive(1'b1, 2'b11, 5'd7, 32'hA, 32'hB);
    cycle();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_wn", 64'(out_wn), 64'd7);
    chk("lat_data", out_data, 64'h0000000A_0000000B);
    chk("lat_ctrl", 64'(out_ctrl), 64'd3);
    cycle();
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_ctrl", 64'(out_ctrl), 64'd0);

    // back-pressure fills SKID
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 5'd1, 32'h11, 32'h12);
    cycle();
    drive(1'b1, 2'b10, 5'd2, 32'h21, 32'h22);
    cycle();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    cycle();
    cycle();
    chk("stall_3", 64'(stall_cnt), 64'd3);
    chk("e1_head", 64'(out_wn), 64'd1);
    out_ready = 1'b1;
    cycle();
    chk("e2_head", 64'(out_wn), 64'd2);
    chk("e2_ctrl", 64'(out_ctrl), 64'd2);
    chk("ready_back", 64'(in_ready), 64'd1);
    cycle();
    chk("drained", 64'(out_valid), 64'd0);

    // flush from FULL discards everything, including concurrent input
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 5'd3, 32'h31, 32'h32);
    cycle();
    drive(1'b1, 2'b11, 5'd4, 32'h41, 32'h42);
    cycle();
    flush = 1'b1;
    drive(1'b1, 2'b11, 5'd9, 32'h91, 32'h92);
    cycle();
    flush = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) cycle();

    // freeze with en_reg=0
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 5'd5, 32'h51, 32'h52);
    cycle();
    en_reg = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 5'd6, 32'h61, 32'h62);
    repeat (3) cycle();
    chk("frz_in_ready", 64'(in_ready), 64'd0);
    chk("frz_out_valid", 64'(out_valid), 64'd0);
    en_reg = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
    #1;
    chk("thaw_valid", 64'(out_valid), 64'd1);
    chk("thaw_wn", 64'(out_wn), 64'd5);
    chk("thaw_data", out_data, 64'h00000051_00000052);
    cycle();
    chk("thaw_empty", 64'(out_valid), 64'd0);

    // streaming with a directed out_ready pattern
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 5) != 2 && (i % 7) != 3;
      drive(1'b1, 2'(i), 5'(i + 10), 32'(i * 3), 32'(i * 5 + 1));
      cycle();
    end
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
    out_ready = 1'b1;
    repeat (3) cycle();

    // stall counter saturation, then async reset mid-run
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 5'd30, 32'hDEAD, 32'hBEEF);
    cycle();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
    repeat (70000) cycle();
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ctrl", 64'(out_ctrl), 64'd0);
    chk("arst_wn", 64'(out_wn), 64'd0);
    chk("arst_data", out_data, 64'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 5'd17, 32'h71, 32'h72);
    cycle();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
